// File: rtl/bcd_stream_divis_checker_pkg.sv
// Shared types and constants for the serial BCD divisibility checker.
// Imported by the checker top and its remainder step.
package bcd_stream_divis_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_MAX_DIGIT = 9;
    localparam int REM_CALC_W    = 8;

    // True when the (divisor, max digits, count width) triple is usable.
    function automatic bit params_ok(int divisor, int max_digits, int cnt_w);
        return (divisor >= 2) && (divisor <= 15) &&
               (max_digits >= 1) && (max_digits <= 255) &&
               (cnt_w < 31) && ((1 << cnt_w) > max_digits);
    endfunction

endpackage

// File: rtl/bcd_stream_divis_checker_if.sv
// Digit stream in, per-number result out.
// Both directions use a valid/ready handshake.
interface bcd_stream_divis_checker_if #(
    parameter int CNT_W = 8
);
    logic             digit_valid;
    logic [3:0]       digit;
    logic             digit_last;
    logic             digit_ready;
    logic             result_valid;
    logic             result_ready;
    logic             divisible;
    logic [3:0]       remainder;
    logic             bad_digit;
    logic             overrun;
    logic [CNT_W-1:0] digit_count;

    modport master (
        output digit_valid,
        output digit,
        output digit_last,
        output result_ready,
        input  digit_ready,
        input  result_valid,
        input  divisible,
        input  remainder,
        input  bad_digit,
        input  overrun,
        input  digit_count
    );

    modport slave (
        input  digit_valid,
        input  digit,
        input  digit_last,
        input  result_ready,
        output digit_ready,
        output result_valid,
        output divisible,
        output remainder,
        output bad_digit,
        output overrun,
        output digit_count
    );
endinterface

// File: rtl/bcd_stream_divis_checker_mod_step.sv
// One MSD-first remainder step: (rem*10 + digit) mod DIVISOR.
// Non-BCD digits still feed the sum; they are only flagged.
module bcd_stream_divis_checker_mod_step
    import bcd_stream_divis_checker_pkg::*;
#(
    parameter int DIVISOR = 3
) (
    input  logic [3:0] rem_in,
    input  logic [3:0] digit,
    output logic [3:0] rem_out,
    output logic       is_bad
);
    localparam logic [REM_CALC_W-1:0] DIV = REM_CALC_W'(DIVISOR);
    localparam logic [REM_CALC_W-1:0] TEN = REM_CALC_W'(10);

    logic [REM_CALC_W-1:0] sum;
    logic [REM_CALC_W-1:0] md;

    // Worst case 14*10+15 = 155 fits in eight bits.
    always_comb begin
        sum     = REM_CALC_W'(rem_in) * TEN + REM_CALC_W'(digit);
        md      = sum % DIV;
        rem_out = md[3:0];
        is_bad  = digit > 4'(BCD_MAX_DIGIT);
    end
endmodule

// File: rtl/bcd_stream_divis_checker.sv
// Serial BCD divisibility checker: MSD-first digit stream,
// running remainder, registered result held until taken.
module bcd_stream_divis_checker
    import bcd_stream_divis_checker_pkg::*;
#(
    parameter int DIVISOR    = 3,
    parameter int MAX_DIGITS = 8,
    parameter int CNT_W      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    bcd_stream_divis_checker_if.slave        bus
);
    localparam bit PARAMS_LEGAL = params_ok(DIVISOR, MAX_DIGITS, CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    state_t           state;
    logic [3:0]       rem;
    logic [CNT_W-1:0] cnt;
    logic             bad;
    logic             ovr;
    logic             div_q;
    logic             rv;

    logic [3:0]       rem_nxt;
    logic             is_bad;
    logic             bad_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             last_hit;

    if (!PARAMS_LEGAL) begin : g_bad_params
        $error("bcd_stream_divis_checker: illegal parameters");
    end

    bcd_stream_divis_checker_mod_step #(
        .DIVISOR (DIVISOR)
    ) u_step (
        .rem_in  (rem),
        .digit   (bus.digit),
        .rem_out (rem_nxt),
        .is_bad  (is_bad)
    );

    assign bus.digit_ready = !rst && (state != ST_DONE);

    always_comb begin
        accept   = bus.digit_valid && bus.digit_ready;
        cnt_nxt  = cnt + CNT_W'(1);
        bad_nxt  = bad | is_bad;
        // Hitting the digit limit ends the number as if digit_last were set.
        last_hit = bus.digit_last || (cnt_nxt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            cnt   <= '0;
            bad   <= 1'b0;
            ovr   <= 1'b0;
            div_q <= 1'b0;
            rv    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        rem <= rem_nxt;
                        cnt <= cnt_nxt;
                        bad <= bad_nxt;
                        if (last_hit) begin
                            state <= ST_DONE;
                            rv    <= 1'b1;
                            ovr   <= !bus.digit_last;
                            div_q <= (rem_nxt == 4'd0) && !bad_nxt;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.result_ready) begin
                        state <= ST_IDLE;
                        rem   <= '0;
                        cnt   <= '0;
                        bad   <= 1'b0;
                        ovr   <= 1'b0;
                        div_q <= 1'b0;
                        rv    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result_valid = rv;
    assign bus.divisible    = div_q;
    assign bus.remainder    = rem;
    assign bus.bad_digit    = bad;
    assign bus.overrun      = ovr;
    assign bus.digit_count  = cnt;
endmodule

// File: tb/tb_bcd_stream_divis_checker.sv
// Scoreboard bench: two checkers (mod 3 and mod 7, 4-digit limit)
// share one digit stream; expectations come from whole-number arithmetic.
module tb_bcd_stream_divis_checker;
    localparam int MAXD = 4;
    localparam int CW   = 8;

    typedef struct {
        int r3;
        int r7;
        bit bad;
        bit ovr;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_stream_divis_checker_if #(.CNT_W(CW)) ia ();
    bcd_stream_divis_checker_if #(.CNT_W(CW)) ib ();

    assign ib.digit_valid  = ia.digit_valid;
    assign ib.digit        = ia.digit;
    assign ib.digit_last   = ia.digit_last;
    assign ib.result_ready = ia.result_ready;

    bcd_stream_divis_checker #(
        .DIVISOR(3), .MAX_DIGITS(MAXD), .CNT_W(CW)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );

    bcd_stream_divis_checker #(
        .DIVISOR(7), .MAX_DIGITS(MAXD), .CNT_W(CW)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   cur[$];
    bit   pending = 1'b0;
    bit   acc = 1'b0;
    bit   last_rst = 1'b1;

    bit   s_valid = 1'b0;
    int   s_digit = 0;
    bit   s_last = 1'b0;
    bit   s_rst = 1'b1;
    int   rr_prob = 100;
    int   rr_hold = 0;

    initial begin
        ia.digit_valid  = 1'b0;
        ia.digit        = 4'd0;
        ia.digit_last   = 1'b0;
        ia.result_ready = 1'b0;
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Whole-number view: value = sum of digit*10^k, then reduce.
    function automatic exp_t model(int q[$], bit last);
        exp_t   e;
        longint v;
        v     = 0;
        e.bad = 1'b0;
        foreach (q[i]) begin
            v = v * 10 + q[i];
            if (q[i] > 9) e.bad = 1'b1;
        end
        e.r3  = int'(v % 3);
        e.r7  = int'(v % 7);
        e.ovr = !last;
        e.cnt = q.size();
        return e;
    endfunction

    task automatic check_cleared();
        chk("rst_valid_a", ia.result_valid, 0);
        chk("rst_rem_a", ia.remainder, 0);
        chk("rst_cnt_a", ia.digit_count, 0);
        chk("rst_bad_a", ia.bad_digit, 0);
        chk("rst_ovr_a", ia.overrun, 0);
        chk("rst_div_a", ia.divisible, 0);
        chk("rst_valid_b", ib.result_valid, 0);
        chk("rst_rem_b", ib.remainder, 0);
        chk("rst_cnt_b", ib.digit_count, 0);
    endtask

    // Drive at posedge+1, observe at posedge+7; monitor runs at negedge.
    task automatic cycle();
        @(posedge clk);
        #1;
        rst             = s_rst;
        ia.digit_valid  = s_valid;
        ia.digit        = 4'(s_digit);
        ia.digit_last   = s_last;
        if (rr_hold > 0) begin
            ia.result_ready = 1'b0;
            rr_hold--;
        end else begin
            ia.result_ready = ($urandom_range(99) < rr_prob);
        end
        #6;
        if (last_rst && !s_rst) check_cleared();
        last_rst = s_rst;
        chk("digit_ready_a", ia.digit_ready, !s_rst && !pending);
        chk("digit_ready_b", ib.digit_ready, !s_rst && !pending);
        acc = s_valid && ia.digit_ready;
        if (s_rst) begin
            cur.delete();
        end else if (pending) begin
            if (ia.result_ready) pending = 1'b0;
        end else if (acc) begin
            cur.push_back(s_digit);
            if (s_last || cur.size() == MAXD) begin
                sb.push_back(model(cur, s_last));
                cur.delete();
                pending = 1'b1;
            end
        end
    endtask

    task automatic send(int d, bit l);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_digit = d;
        s_last  = l;
        s_rst   = 1'b0;
        do begin
            cycle();
            n++;
        end while (!acc && n < 60);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout digit=%0d never accepted", d);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("result_valid", ia.result_valid, sb.size() != 0);
                chk("result_valid_b", ib.result_valid, sb.size() != 0);
                if (ia.result_valid && sb.size() != 0) begin
                    e = sb[0];
                    chk("remainder_a", ia.remainder, e.r3);
                    chk("divisible_a", ia.divisible, e.r3 == 0 && !e.bad);
                    chk("remainder_b", ib.remainder, e.r7);
                    chk("divisible_b", ib.divisible, e.r7 == 0 && !e.bad);
                    chk("bad_digit", ia.bad_digit, e.bad);
                    chk("overrun", ia.overrun, e.ovr);
                    chk("digit_count", ia.digit_count, e.cnt);
                    chk("bad_digit_b", ib.bad_digit, e.bad);
                    chk("overrun_b", ib.overrun, e.ovr);
                    if (ia.result_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : driver
        int r;
        int d;
        int n;
        s_rst = 1'b1;
        repeat (3) idle();
        s_rst = 1'b0;

        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        send(9, 0); send(9, 0); send(9, 0); send(9, 1);
        send(1, 0); send(0, 0); send(0, 0); send(1, 1);
        send(1, 0); send(0, 0); send(0, 0); send(2, 1);
        send(3, 0); send(10, 0); send(6, 1);
        idle();

        // Overrun after four digits; fifth waits out a 3-cycle consumer stall.
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        rr_hold = 3;
        send(5, 1);
        idle();

        // Reset in the middle of a number drops it.
        send(2, 0); send(7, 0);
        s_rst = 1'b1;
        idle(); idle();
        s_rst = 1'b0;
        send(6, 1);
        idle();

        rr_prob = 60;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99);
            if (r < 15) begin
                s_rst = (r < 3) && !pending;
                idle();
                s_rst = 1'b0;
            end else begin
                if ($urandom_range(9) == 0) d = $urandom_range(15, 10);
                else d = $urandom_range(9);
                send(d, $urandom_range(99) < 30);
            end
        end

        rr_prob = 100;
        n = 0;
        while ((sb.size() != 0 || pending) && n < 50) begin
            idle();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left=%0d results unconsumed", sb.size());
        end
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
